// File: rtl/ddr_rd_pkg.sv
// Shared constants, FSM state type and beat-count helper for the DDR read-back engine.
package ddr_rd_pkg;

    localparam logic [31:0] CMD_RD_DEFAULT = 32'h0000_0020;
    localparam int          BEAT_BYTES     = 32;
    localparam int          WORDS_PER_BEAT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } rd_state_t;

    // ceil(len / 32); 28 bits so that len = 2^32-1 cannot overflow
    function automatic logic [27:0] beat_count(input logic [31:0] len);
        return {1'b0, len[31:5]} + {27'd0, |len[4:0]};
    endfunction

endpackage

// File: rtl/beat_to_word_ser.sv
// Holds one 256-bit read beat and emits it as eight 32-bit words, low word first.
module beat_to_word_ser
    import ddr_rd_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         load_last,
    input  logic [255:0] load_data,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_valid,
    output logic         out_last,
    output logic         empty,
    output logic         drained
);

    logic [255:0] beat_q;
    logic [2:0]   idx_q;
    logic         full_q;
    logic         last_q;
    logic         empty_q;
    logic         fire;
    logic         word_end;

    assign fire     = full_q & out_ready;
    assign word_end = fire & (idx_q == 3'(WORDS_PER_BEAT - 1));

    // empty is registered so rready comes out of reset low and rises on the first clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q  <= '0;
            idx_q   <= '0;
            full_q  <= 1'b0;
            last_q  <= 1'b0;
            empty_q <= 1'b0;
        end else begin
            empty_q <= !(load | (full_q & !word_end));
            if (load) begin
                beat_q <= load_data;
                idx_q  <= '0;
                full_q <= 1'b1;
                last_q <= load_last;
            end else if (fire) begin
                idx_q <= idx_q + 3'd1;
                if (word_end) begin
                    full_q <= 1'b0;
                end
            end
        end
    end

    assign out_data  = beat_q[{idx_q, 5'd0} +: 32];
    assign out_valid = full_q;
    assign out_last  = full_q & last_q & (idx_q == 3'(WORDS_PER_BEAT - 1));
    assign empty     = empty_q;
    assign drained   = word_end & last_q;

endmodule

// File: rtl/ddr_rd_to_stream.sv
// DDR read-back engine: single-beat AXI reads from base for len bytes, streamed as 32-bit words.
//   state | meaning
//   IDLE  | waiting for a command edge
//   ADDR  | arvalid high, waiting for arready
//   DATA  | one read outstanding, waiting to capture the beat
//   DRAIN | all beats captured, waiting for the final word to leave
module ddr_rd_to_stream
    import ddr_rd_pkg::*;
#(
    parameter logic [31:0] CMD_RD = CMD_RD_DEFAULT
) (
    input  logic         ddr_clk,
    input  logic         ddr_rst_n,
    input  logic [31:0]  rd_ddr_len,
    input  logic [31:0]  rd_ddr_cmd,
    input  logic [31:0]  rd_ddr_baseaddr,
    output logic [27:0]  ddr_axi_araddr,
    output logic [3:0]   ddr_axi_aruser_id,
    output logic [3:0]   ddr_axi_arlen,
    output logic         ddr_axi_arvalid,
    input  logic         ddr_axi_arready,
    input  logic [255:0] ddr_axi_rdata,
    input  logic         ddr_axi_rlast,
    input  logic         ddr_axi_rvalid,
    output logic         ddr_axi_rready,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         done
);

    rd_state_t   state_q;
    rd_state_t   state_d;
    logic        cmd_prev_q;
    logic        start_q;
    logic        done_q;
    logic [27:0] beats_left_q;
    logic [27:0] addr_q;
    logic        cmd_hit;
    logic        len_zero;
    logic        ar_fire;
    logic        r_fire;
    logic        ser_empty;
    logic        ser_drained;
    logic        unused_addr_hi;

    assign cmd_hit        = (rd_ddr_cmd == CMD_RD);
    assign len_zero       = (rd_ddr_len == 32'd0);
    assign ar_fire        = ddr_axi_arvalid & ddr_axi_arready;
    assign r_fire         = ddr_axi_rvalid & ser_empty;
    assign unused_addr_hi = ^rd_ddr_baseaddr[31:28];

    always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
        if (!ddr_rst_n) begin
            state_q    <= IDLE;
            cmd_prev_q <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_prev_q <= cmd_hit;
            start_q    <= cmd_hit & !cmd_prev_q;
            done_q     <= ((state_q == IDLE) & start_q & len_zero) |
                          ((state_q == DRAIN) & ser_drained);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_q && !len_zero) state_d = ADDR;
            ADDR:    if (ddr_axi_arready) state_d = DATA;
            DATA:    if (r_fire && ddr_axi_rlast) state_d = (beats_left_q == 28'd1) ? DRAIN : ADDR;
            DRAIN:   if (ser_drained) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ddr_axi_arvalid = (state_q == ADDR);
        busy            = (state_q != IDLE);
    end

    // beats_left counts down to the terminal value 1 on the final beat
    always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
        if (!ddr_rst_n) begin
            beats_left_q <= '0;
            addr_q       <= '0;
        end else if (state_q == IDLE && start_q) begin
            beats_left_q <= beat_count(rd_ddr_len);
            addr_q       <= rd_ddr_baseaddr[27:0];
        end else begin
            if (ar_fire) begin
                addr_q <= addr_q + 28'(BEAT_BYTES);
            end
            if (r_fire && ddr_axi_rlast && state_q == DATA) begin
                beats_left_q <= beats_left_q - 28'd1;
            end
        end
    end

    beat_to_word_ser u_ser (
        .clk       (ddr_clk),
        .rst_n     (ddr_rst_n),
        .load      (r_fire),
        .load_last (beats_left_q == 28'd1),
        .load_data (ddr_axi_rdata),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .empty     (ser_empty),
        .drained   (ser_drained)
    );

    assign ddr_axi_araddr    = addr_q;
    assign ddr_axi_aruser_id = 4'h0;
    assign ddr_axi_arlen     = 4'h0;
    assign ddr_axi_rready    = ser_empty;
    assign done              = done_q;

endmodule
